ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/ram_port_arbiter_sat_counter.sv | 30 +++
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and state encodings for the RAM port arbiter and its helpers.
package mem_arb_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int STARVE_W = 4;
  localparam int CONFL_W  = 16;

  typedef enum logic [0:0] {
    PRI_CPU  = 1'b0,
    PRI_HOST = 1'b1
  } pri_state_e;

  typedef enum logic [0:0] {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; reset and clear both return it to zero.
module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Clear has priority over increment; the count sticks at MAX instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != MAX)) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for RAM port A: CPU normally wins, host is guaranteed
// one grant after STARVE_LIMIT consecutive denied cycles.
module ram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CONFL_W-1:0] conflict_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  pri_state_e          pri_state_r;
  owner_e              owner_r;
  logic                rd_valid_r;
  logic                cpu_win_s;
  logic                host_win_s;
  logic                starve_inc_s;
  logic                starve_hit_s;
  logic                conflict_s;
  logic [STARVE_W-1:0] starve_cnt_s;

  // Grant selection: host wins when alone or when the FSM has handed it priority.
  always_comb begin
    cpu_win_s  = 1'b0;
    host_win_s = 1'b0;
    if (!reset) begin
      cpu_win_s  = 1'b0;
      host_win_s = 1'b0;
    end else if (host_req && (!cpu_req || (pri_state_r == PRI_HOST))) begin
      host_win_s = 1'b1;
    end else if (cpu_req) begin
      cpu_win_s = 1'b1;
    end else begin
      cpu_win_s  = 1'b0;
      host_win_s = 1'b0;
    end
  end

  assign cpu_gnt   = cpu_win_s;
  assign host_gnt  = host_win_s;
  assign cpu_stall = cpu_req & ~cpu_win_s;
  assign ram_en    = cpu_win_s | host_win_s;

  // Port A mux: winner's request fields, all zero when nobody is granted.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    case ({cpu_win_s, host_win_s})
      2'b10: begin
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      2'b01: begin
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
      end
      default: begin
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  assign starve_inc_s = reset & host_req & ~host_win_s;
  assign starve_hit_s = starve_inc_s && (starve_cnt_s == (STARVE_MAX - {{(STARVE_W-1){1'b0}}, 1'b1}));
  assign conflict_s   = cpu_req & host_req;

  sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc_s),
    .clr   (host_win_s),
    .count (starve_cnt_s)
  );

  sat_counter #(
    .WIDTH (CONFL_W),
    .MAX   ({CONFL_W{1'b1}})
  ) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict_s),
    .clr   (1'b0),
    .count (conflict_cnt)
  );

  // Priority FSM: hand priority to the host when it starves, take it back after one host grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pri_state_r <= PRI_CPU;
    end else begin
      case (pri_state_r)
        PRI_CPU: begin
          if (starve_hit_s) begin
            pri_state_r <= PRI_HOST;
          end else begin
            pri_state_r <= PRI_CPU;
          end
        end
        PRI_HOST: begin
          if (host_win_s) begin
            pri_state_r <= PRI_CPU;
          end else begin
            pri_state_r <= PRI_HOST;
          end
        end
        default: pri_state_r <= PRI_CPU;
      endcase
    end
  end

  // Read return pipeline: remember who issued the read so the data goes back to them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_r <= 1'b0;
      owner_r    <= OWN_CPU;
    end else begin
      rd_valid_r <= (cpu_win_s & ~cpu_we) | (host_win_s & ~host_we);
      owner_r    <= host_win_s ? OWN_HOST : OWN_CPU;
    end
  end

  // Gating with reset kills a read that was in flight when reset arrived.
  assign cpu_rvalid  = reset & rd_valid_r & (owner_r == OWN_CPU);
  assign host_rvalid = reset & rd_valid_r & (owner_r == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : {DATA_W{1'b0}};
  assign host_rdata  = host_rvalid ? ram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM on port A.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [9:0]  cpu_addr, host_addr;
  logic [15:0] cpu_wdata, host_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic [15:0] cpu_rdata, host_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata, conflict_cnt;
  logic [15:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;
  logic exp_h, prev_h;

  always #5 clk = ~clk;

  ram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  // RAM model: writes land at the edge, reads return on the following cycle.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 10'h000; host_wdata = 16'h0000;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    go_idle();
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    check_eq("preload_host_gnt", 32'(host_gnt), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    go_idle();
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1; host_req = 1'b1;
    #1;
    check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_eq("rst_host_gnt", 32'(host_gnt), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_rvalid", 32'({cpu_rvalid, host_rvalid}), 32'd0);
    check_eq("rst_conflict", 32'(conflict_cnt), 32'd0);

    @(negedge clk);
    go_idle();
    reset = 1'b1;
    #1;
    check_eq("idle_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);

    host_write(10'h005, 16'h1234);
    host_write(10'h001, 16'hAAAA);
    host_write(10'h002, 16'h5555);

    // CPU-only read of 0x005
    @(negedge clk);
    go_idle();
    cpu_req = 1'b1; cpu_addr = 10'h005;
    #1;
    check_eq("s1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("s1_stall", 32'(cpu_stall), 32'd0);
    check_eq("s1_ram_addr", 32'(ram_addr), 32'h005);
    check_eq("s1_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    go_idle();
    #1;
    check_eq("s1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("s1_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    check_eq("s1_host_rvalid", 32'(host_rvalid), 32'd0);
    check_eq("s1_host_rdata", 32'(host_rdata), 32'd0);
    @(negedge clk);
    #1;
    check_eq("s1_rvalid_once", 32'(cpu_rvalid), 32'd0);

    // Both request reads continuously: host wins every fifth cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 10'h001;
    host_req = 1'b1; host_addr = 10'h002;
    prev_h = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_h = ((i % 5) == 4);
      check_eq($sformatf("s2_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'(!exp_h));
      check_eq($sformatf("s2_host_gnt_%0d", i), 32'(host_gnt), 32'(exp_h));
      check_eq($sformatf("s2_stall_%0d", i), 32'(cpu_stall), 32'(exp_h));
      if (i > 0) begin
        check_eq($sformatf("s2_cpu_rv_%0d", i), 32'(cpu_rvalid), 32'(!prev_h));
        check_eq($sformatf("s2_host_rv_%0d", i), 32'(host_rvalid), 32'(prev_h));
        check_eq($sformatf("s2_cpu_rd_%0d", i), 32'(cpu_rdata), 32'(prev_h ? 16'h0000 : 16'hAAAA));
        check_eq($sformatf("s2_host_rd_%0d", i), 32'(host_rdata), 32'(prev_h ? 16'h5555 : 16'h0000));
      end
      prev_h = exp_h;
      @(negedge clk);
    end
    go_idle();
    #1;
    check_eq("s2_last_host_rv", 32'(host_rvalid), 32'd1);
    check_eq("s2_last_host_rd", 32'(host_rdata), 32'h5555);
    check_eq("s2_last_cpu_rv", 32'(cpu_rvalid), 32'd0);
    check_eq("s2_conflicts", 32'(conflict_cnt), 32'd10);

    // Host write while CPU idle, then CPU reads it back
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h200; host_wdata = 16'hBEEF;
    #1;
    check_eq("s3_host_gnt", 32'(host_gnt), 32'd1);
    check_eq("s3_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_eq("s3_ram_we", 32'(ram_we), 32'd1);
    check_eq("s3_ram_addr", 32'(ram_addr), 32'h200);
    check_eq("s3_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    @(negedge clk);
    go_idle();
    cpu_req = 1'b1; cpu_addr = 10'h200;
    #1;
    check_eq("s3_wr_no_rvalid", 32'(host_rvalid), 32'd0);
    check_eq("s3_cpu_gnt_rd", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    go_idle();
    #1;
    check_eq("s3_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

    // Alternating single requesters
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 10'h001;
    #1;
    check_eq("s4_cpu_gnt", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    go_idle();
    host_req = 1'b1; host_addr = 10'h002;
    #1;
    check_eq("s4_host_gnt", 32'(host_gnt), 32'd1);
    check_eq("s4_cpu_rv", 32'(cpu_rvalid), 32'd1);
    check_eq("s4_cpu_rd", 32'(cpu_rdata), 32'hAAAA);
    check_eq("s4_host_rv_early", 32'(host_rvalid), 32'd0);
    check_eq("s4_host_rd_early", 32'(host_rdata), 32'd0);
    @(negedge clk);
    go_idle();
    #1;
    check_eq("s4_host_rv", 32'(host_rvalid), 32'd1);
    check_eq("s4_host_rd", 32'(host_rdata), 32'h5555);
    check_eq("s4_cpu_rv_late", 32'(cpu_rvalid), 32'd0);
    check_eq("s4_cpu_rd_late", 32'(cpu_rdata), 32'd0);

    // Reset right after a CPU read grant, with the FSM just moved to PRI_HOST
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 10'h005;
    host_req = 1'b1; host_addr = 10'h002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("s5_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'd1);
      @(negedge clk);
    end
    go_idle();
    reset = 1'b0;
    #1;
    check_eq("s5_rst_cpu_rv", 32'(cpu_rvalid), 32'd0);
    check_eq("s5_rst_cpu_rd", 32'(cpu_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_addr = 10'h005;
    host_req = 1'b1; host_addr = 10'h002;
    #1;
    check_eq("s5_conflict_clr", 32'(conflict_cnt), 32'd0);
    check_eq("s5_no_rv", 32'(cpu_rvalid), 32'd0);
    check_eq("s5_pri_cpu", 32'(cpu_gnt), 32'd1);
    check_eq("s5_pri_host", 32'(host_gnt), 32'd0);

    // Conflict counter saturation from a preloaded value
    @(negedge clk);
    go_idle();
    force dut.u_conflict_cnt.count_r = 16'hFFFE;
    #1;
    release dut.u_conflict_cnt.count_r;
    #1;
    check_eq("s6_preload", 32'(conflict_cnt), 32'hFFFE);
    cpu_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("s6_sat_%0d", i), 32'(conflict_cnt), 32'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
